// File: rtl/pipe_pkg.sv
// Shared types, default widths and helpers for the elastic pipeline stage buffer.
package pipe_pkg;

    localparam int DEFAULT_DATA_W = 256;
    localparam int DEFAULT_CTRL_W = 16;
    localparam int DEFAULT_CNT_W  = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    // Increment that sticks at the all-ones value of a counter of the given width.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
        logic [63:0] max_v;
        if (width >= 32'd64) begin
            max_v = {64{1'b1}};
        end else begin
            max_v = (64'd1 << width) - 64'd1;
        end
        if (value >= max_v) begin
            sat_inc = max_v;
        end else begin
            sat_inc = value + 64'd1;
        end
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One storage slot of the stage buffer: control word plus payload with load enable.
module pipe_entry #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_r;

    // Entry register; holds its contents unless explicitly loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r <= '0;
        end else if (load) begin
            q_r <= d;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: main + skid entries behind a valid/ready handshake, with
// registered in_ready, flush-to-bubble, NOP control gating and a saturating stall counter.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                 DATA_W   = DEFAULT_DATA_W,
    parameter int                 CTRL_W   = DEFAULT_CTRL_W,
    parameter logic [CTRL_W-1:0]  NOP_CTRL = '0,
    parameter int                 CNT_W    = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int ENTRY_W = CTRL_W + DATA_W;

    pipe_state_e        state_r;
    pipe_state_e        state_nxt_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [CNT_W-1:0]   stall_cnt_r;
    logic [1:0]         occupancy_s;

    logic               accept_s;
    logic               release_s;
    logic               load_main_s;
    logic               load_skid_s;
    logic               main_from_skid_s;
    logic [ENTRY_W-1:0] in_entry_s;
    logic [ENTRY_W-1:0] main_d_s;
    logic [ENTRY_W-1:0] main_q_s;
    logic [ENTRY_W-1:0] skid_q_s;

    assign accept_s   = in_valid & in_ready_r;
    assign release_s  = out_valid_r & out_ready;
    assign in_entry_s = {in_ctrl, in_data};
    assign main_d_s   = main_from_skid_s ? skid_q_s : in_entry_s;

    // Next-state and entry load decisions; flush overrides all movement and loads nothing.
    always_comb begin
        state_nxt_s      = state_r;
        load_main_s      = 1'b0;
        load_skid_s      = 1'b0;
        main_from_skid_s = 1'b0;
        if (flush) begin
            state_nxt_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s = ONE;
                        load_main_s = 1'b1;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && release_s) begin
                        state_nxt_s = ONE;
                        load_main_s = 1'b1;
                    end else if (accept_s) begin
                        state_nxt_s = TWO;
                        load_skid_s = 1'b1;
                    end else if (release_s) begin
                        state_nxt_s = EMPTY;
                    end else begin
                        state_nxt_s = ONE;
                    end
                end
                TWO: begin
                    if (release_s) begin
                        state_nxt_s      = ONE;
                        load_main_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                    end else begin
                        state_nxt_s = TWO;
                    end
                end
                default: begin
                    state_nxt_s = EMPTY;
                end
            endcase
        end
    end

    // State, handshake flags and stall counter; in_ready is decided one edge ahead.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= EMPTY;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            stall_cnt_r <= '0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s != TWO);
            out_valid_r <= (state_nxt_s != EMPTY);
            if (out_valid_r && !out_ready) begin
                stall_cnt_r <= CNT_W'(sat_inc(64'(stall_cnt_r), CNT_W));
            end
        end
    end

    // Beat count decoded from the held state.
    always_comb begin
        occupancy_s = 2'd0;
        case (state_r)
            EMPTY:   occupancy_s = 2'd0;
            ONE:     occupancy_s = 2'd1;
            TWO:     occupancy_s = 2'd2;
            default: occupancy_s = 2'd0;
        endcase
    end

    pipe_entry #(.W(ENTRY_W)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (load_main_s),
        .d     (main_d_s),
        .q     (main_q_s)
    );

    pipe_entry #(.W(ENTRY_W)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (load_skid_s),
        .d     (in_entry_s),
        .q     (skid_q_s)
    );

    // Bubbles always present NOP control so no live control leaks downstream.
    assign out_ctrl  = out_valid_r ? main_q_s[ENTRY_W-1 -: CTRL_W] : NOP_CTRL;
    assign out_data  = main_q_s[DATA_W-1:0];
    assign out_valid = out_valid_r;
    assign in_ready  = in_ready_r;
    assign occupancy = occupancy_s;
    assign stall_cnt = stall_cnt_r;

endmodule
